// File: rtl/axi_burst_rom.sv
// axi_burst_rom: read-only AXI-style burst slave used for instruction-cache refills.
// Accepts one AR request at a time. After a programmable latency it returns N
// INCR beats of 64-bit words. A request that is illegal or that runs past the
// array returns SLVERR beats carrying zero data.
module axi_burst_rom #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 65536,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = "inst.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  input  logic [1:0]  arburst,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic        rlast,
  input  logic        rready
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  logic [63:0] mem_q [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  n_q, n_d;
  logic [31:0] w0_q, w0_d;
  logic        err_q, err_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [63:0] rdata_q, rdata_d;

  logic        hs_s;
  logic [31:0] req_w0_s;
  logic [7:0]  req_n_s;
  logic [31:0] req_last_idx_s;
  logic        req_err_s;
  logic        load_s;
  logic [31:0] load_idx_s;
  logic        load_err_s;
  logic        load_last_s;

  assign arready = (state_q == S_IDLE) & rst;
  assign hs_s    = arvalid & arready;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  // Request decode: word index of beat 0, beat count and legality of the whole burst.
  // W0 stays below 2^29 so adding up to 255 beats cannot wrap the 32-bit index.
  assign req_w0_s       = (araddr - BASE_ADDR) >> 3;
  assign req_n_s        = (arlen == 8'd0) ? 8'd1 : arlen;
  assign req_last_idx_s = req_w0_s + {24'd0, req_n_s} - 32'd1;
  assign req_err_s      = (arburst != 2'b01) | (arsize != 3'd3) |
                          (araddr < BASE_ADDR) | (req_last_idx_s >= DEPTH_W);

  // Next-state and beat sequencing; load_s marks an edge that presents a new beat
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    n_d         = n_q;
    w0_d        = w0_q;
    err_d       = err_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    load_s      = 1'b0;
    load_idx_s  = w0_q;
    load_err_s  = err_q;
    load_last_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          w0_d   = req_w0_s;
          n_d    = req_n_s;
          err_d  = req_err_s;
          beat_d = 8'd0;
          lat_d  = 4'd0;
          if (LATENCY == 0) begin
            state_d     = S_BURST;
            load_s      = 1'b1;
            load_idx_s  = req_w0_s;
            load_err_s  = req_err_s;
            load_last_s = (req_n_s == 8'd1);
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d     = S_BURST;
          load_s      = 1'b1;
          load_idx_s  = w0_q;
          load_last_s = (n_q == 8'd1);
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_BURST: begin
        if (rready) begin
          if (rlast_q) begin
            state_d  = S_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rresp_d  = 2'b00;
          end else begin
            beat_d      = beat_q + 8'd1;
            load_s      = 1'b1;
            load_idx_s  = w0_q + {24'd0, beat_q} + 32'd1;
            load_last_s = ((beat_q + 8'd1) == (n_q - 8'd1));
          end
        end else begin
          state_d = S_BURST;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        rresp_d  = 2'b00;
      end
    endcase
    if (load_s) begin
      rvalid_d = 1'b1;
      rlast_d  = load_last_s;
      rresp_d  = load_err_s ? 2'b10 : 2'b00;
    end else begin
      rvalid_d = rvalid_d;
    end
  end

  // Beat data fetch: zero for errored bursts or any index outside the array
  always_comb begin
    rdata_d = rdata_q;
    if (load_s) begin
      if (load_err_s || (load_idx_s >= DEPTH_W)) begin
        rdata_d = 64'd0;
      end else begin
        rdata_d = mem_q[load_idx_s[AW-1:0]];
      end
    end else if (state_d == S_IDLE) begin
      rdata_d = 64'd0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      lat_q    <= 4'd0;
      beat_q   <= 8'd0;
      n_q      <= 8'd0;
      w0_q     <= 32'd0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= 64'd0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      n_q      <= n_d;
      w0_q     <= w0_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_rom.sv
// Directed bench for axi_burst_rom. Expected beats are queued when a request is
// issued and compared by a negedge monitor; timing is checked inline.
module tb_axi_burst_rom;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        rready;

  logic        arready, rvalid, rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        d0_arready, d0_rvalid, d0_rlast;
  logic [63:0] d0_rdata;
  logic [1:0]  d0_rresp;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    err_cnt = 0;
  int    chk_cnt = 0;
  int    acc_cnt = 0;

  axi_burst_rom #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
    .arlen(arlen), .arsize(arsize), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  axi_burst_rom #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
    .arlen(arlen), .arsize(arsize), .arready(d0_arready), .rdata(d0_rdata), .rresp(d0_rresp),
    .rvalid(d0_rvalid), .rlast(d0_rlast), .rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [31:0] i);
    return {8'hA5, i[23:0], i * 32'h9E37_79B9};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid beat must match the scoreboard head; pop on acceptance
  always @(negedge clk) begin
    if (rst && rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(rvalid), 64'd0);
      end else begin
        check("rdata", rdata, exp_q[0].data);
        check("rresp", 64'(rresp), 64'(exp_q[0].resp));
        check("rlast", 64'(rlast), 64'(exp_q[0].last));
        if (rready) begin
          void'(exp_q.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] b, input logic [2:0] s);
    int          n;
    logic [31:0] w0;
    logic        e;
    n  = (len == 8'd0) ? 1 : int'(len);
    w0 = (a - BASE) >> 3;
    e  = (b != 2'b01) || (s != 3'd3) || (a < BASE) || ((w0 + 32'(n) - 32'd1) >= 32'(DEPTH));
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{data: (e ? 64'd0 : pat(w0 + 32'(k))), resp: (e ? 2'b10 : 2'b00),
                        last: (k == n - 1)});
    end
    check("arready_before_issue", 64'(arready), 64'd1);
    araddr  = a;
    arlen   = len;
    arburst = b;
    arsize  = s;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || arready !== 1'b1) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_complete"}, 64'((exp_q.size() == 0) && (arready === 1'b1)), 64'd1);
    check({tag, "_rvalid_low"}, 64'(rvalid), 64'd0);
  endtask

  initial begin
    int acc_base;
    int n;
    bit stall1, stall2;

    rst     = 1'b0;
    arvalid = 1'b1;
    araddr  = 32'h8000_0040;
    arlen   = 8'd8;
    arburst = 2'b01;
    arsize  = 3'd3;
    rready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      u_dut.mem_q[i]  = pat(32'(i));
      u_dut0.mem_q[i] = pat(32'(i));
    end

    // Reset held with a pending request
    repeat (3) begin
      tick();
      check("reset_arready", 64'(arready), 64'd0);
      check("reset_rvalid", 64'(rvalid), 64'd0);
      check("reset_rlast", 64'(rlast), 64'd0);
      check("reset_rdata", rdata, 64'd0);
    end
    rst     = 1'b1;
    arvalid = 1'b0;
    tick();
    check("post_reset_arready", 64'(arready), 64'd1);
    check("post_reset_rvalid", 64'(rvalid), 64'd0);

    // Line refill with latency 2
    rready = 1'b1;
    issue(32'h8000_0040, 8'd8, 2'b01, 3'd3);
    check("lat_t1_rvalid", 64'(rvalid), 64'd0);
    check("lat_t1_arready", 64'(arready), 64'd0);
    tick();
    check("lat_t2_rvalid", 64'(rvalid), 64'd0);
    tick();
    check("lat_t3_rvalid", 64'(rvalid), 64'd1);
    check("lat_t3_rdata", rdata, pat(32'd8));
    wait_idle("refill");

    // Backpressure on beats 2 and 5
    acc_base = acc_cnt;
    stall1   = 1'b0;
    stall2   = 1'b0;
    issue(32'h8000_0040, 8'd8, 2'b01, 3'd3);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      if (rvalid && !stall1 && (acc_cnt - acc_base == 1)) begin
        stall1 = 1'b1;
        rready = 1'b0;
        repeat (3) tick();
        rready = 1'b1;
      end else if (rvalid && !stall2 && (acc_cnt - acc_base == 4)) begin
        stall2 = 1'b1;
        rready = 1'b0;
        repeat (3) tick();
        rready = 1'b1;
      end else begin
        tick();
      end
      n++;
    end
    wait_idle("backpressure");
    check("backpressure_beats", 64'(acc_cnt - acc_base), 64'd8);
    check("backpressure_stalls", 64'({stall1, stall2}), 64'd3);

    // Error responses
    issue(32'h8000_0040, 8'd4, 2'b10, 3'd3);
    wait_idle("err_burst");
    issue(32'h7FFF_FFF8, 8'd2, 2'b01, 3'd3);
    wait_idle("err_below_base");
    issue(32'h8000_0040, 8'd3, 2'b01, 3'd2);
    wait_idle("err_size");
    issue(32'h8000_01F0, 8'd4, 2'b01, 3'd3);
    wait_idle("err_overflow");

    // Edge lengths and alignment
    issue(32'h8000_0010, 8'd0, 2'b01, 3'd3);
    tick();
    tick();
    check("single_rvalid", 64'(rvalid), 64'd1);
    check("single_rlast", 64'(rlast), 64'd1);
    wait_idle("single");
    issue(32'h8000_0047, 8'd2, 2'b01, 3'd3);
    wait_idle("unaligned");

    // Zero-latency instance: first beat right after the handshake edge
    issue(32'h8000_0080, 8'd3, 2'b01, 3'd3);
    check("lat0_t1_rvalid", 64'(d0_rvalid), 64'd1);
    check("lat0_t1_rdata", d0_rdata, pat(32'd16));
    check("lat0_t1_rlast", 64'(d0_rlast), 64'd0);
    tick();
    check("lat0_t2_rdata", d0_rdata, pat(32'd17));
    tick();
    check("lat0_t3_rdata", d0_rdata, pat(32'd18));
    check("lat0_t3_rlast", 64'(d0_rlast), 64'd1);
    tick();
    check("lat0_end_rvalid", 64'(d0_rvalid), 64'd0);
    wait_idle("lat0");

    // Reset in the middle of a burst
    acc_base = acc_cnt;
    issue(32'h8000_0040, 8'd8, 2'b01, 3'd3);
    n = 0;
    while ((acc_cnt - acc_base) < 3 && n < 50) begin
      tick();
      n++;
    end
    check("midburst_reached_beat3", 64'(acc_cnt - acc_base), 64'd3);
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_rlast", 64'(rlast), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    check("midrst_rresp", 64'(rresp), 64'd0);
    check("midrst_arready", 64'(arready), 64'd0);
    rst = 1'b1;
    repeat (4) begin
      tick();
      check("no_residual_rvalid", 64'(rvalid), 64'd0);
    end
    issue(32'h8000_0000, 8'd8, 2'b01, 3'd3);
    wait_idle("after_reset_burst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
